// File: rtl/game_pkg.sv
// Shared game definitions: player state encoding and keyboard codes used by
// the stickman controller and the obstacle blocks.
package game_pkg;

    // Player state; the numeric values are what state_o reports.
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2,
        ST_DUCK = 2'd3
    } stick_state_e;

    localparam int STATE_W = 2;

    // Keyboard scan codes.
    localparam logic [7:0] KEY_JUMP = 8'h2C;
    localparam logic [7:0] KEY_DUCK = 8'h51;

endpackage

// File: rtl/frame_tick.sv
// Frame strobe synchroniser: brings the asynchronous frame_clk level into the
// Clk domain and emits a single-cycle tick on each of its rising edges.
module frame_tick (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clear,
    input  logic frame_clk,
    output logic tick
);

    logic [1:0] sync;
    logic       prev;

    // Two-flop synchroniser followed by a registered rising-edge detector.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync <= '0;
            prev <= 1'b0;
            tick <= 1'b0;
        end else if (clear) begin
            sync <= '0;
            prev <= 1'b0;
            tick <= 1'b0;
        end else begin
            sync <= {sync[0], frame_clk};
            prev <= sync[1];
            tick <= sync[1] & ~prev;
        end
    end

endmodule

// File: rtl/stickman_ctrl.sv
// Stickman player controller: run/jump/fall/duck state machine with simple
// ballistic motion once per frame, run-cycle animation paging, and the
// per-pixel sprite lookup against an external row ROM.
module stickman_ctrl
    import game_pkg::*;
#(
    parameter int X_POS   = 100,
    parameter int Y_START = 250,
    parameter int Y_MIN   = 10,
    parameter int SPR_W   = 56,
    parameter int SPR_H   = 80,
    parameter int DUCK_H  = 48,
    parameter int N_RUN   = 9,
    parameter int FPP     = 2,
    parameter int V_JUMP  = 12,
    parameter int V_CUT   = 4,
    parameter int GRAV    = 1,
    parameter int V_MAX   = 10,
    parameter int ADDR_W  = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    input  logic              restart,
    input  logic [7:0]        keycode,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        GroundY,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [SPR_W-1:0]  rom_data,
    output logic [9:0]        StickmanTop,
    output logic [STATE_W-1:0] state_o,
    output logic              is_stickman
);

    localparam int PAGE_W = $clog2(N_RUN + 2);
    localparam int FC_W   = $clog2(FPP + 1);
    localparam int CW     = $clog2(SPR_W);

    // Gravity step with terminal-speed saturation.
    function automatic logic signed [11:0] vy_grav(input logic signed [11:0] v);
        logic signed [11:0] s;
        s = v + $signed(12'(GRAV));
        return (s > $signed(12'(V_MAX))) ? $signed(12'(V_MAX)) : s;
    endfunction

    // Early jump release caps the remaining upward speed.
    function automatic logic signed [11:0] rise_cut(input logic signed [11:0] v,
                                                    input logic               cut);
        if (cut && (v < -$signed(12'(V_CUT))))
            return -$signed(12'(V_CUT));
        return v;
    endfunction

    logic                tick;
    stick_state_e        state, st_n;
    logic [9:0]          y, y_n;
    logic signed [11:0]  vy, vy_n;
    logic [PAGE_W-1:0]   page, page_n, disp_page;
    logic [FC_W-1:0]     fcnt, fcnt_n;
    logic signed [11:0]  y_step;
    logic signed [11:0]  vy_upd;
    logic signed [10:0]  dx, dy;
    logic                in_box, duck_hide;
    logic [CW-1:0]       col_idx;

    frame_tick u_tick (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .clear     (restart),
        .frame_clk (frame_clk),
        .tick      (tick)
    );

    assign y_step = $signed({2'b00, y}) + vy;
    assign vy_upd = rise_cut(vy_grav(vy), (state == ST_RISE) && (keycode != KEY_JUMP));

    // Next-frame state, position, velocity and animation counters.
    always_comb begin
        st_n   = state;
        y_n    = y;
        vy_n   = vy;
        page_n = page;
        fcnt_n = fcnt;
        unique case (state)
            ST_RUN: begin
                if (fcnt == FC_W'(FPP - 1)) begin
                    fcnt_n = '0;
                    page_n = (page == PAGE_W'(N_RUN - 1)) ? '0 : page + PAGE_W'(1);
                end else begin
                    fcnt_n = fcnt + FC_W'(1);
                end
                if (keycode == KEY_JUMP) begin
                    st_n = ST_RISE;
                    vy_n = -$signed(12'(V_JUMP));
                end else if (keycode == KEY_DUCK) begin
                    st_n = ST_DUCK;
                end else if (({2'b00, y} + 12'(SPR_H)) < {2'b00, GroundY}) begin
                    st_n = ST_FALL;
                    vy_n = '0;
                end
            end
            ST_DUCK: begin
                if (keycode != KEY_DUCK)
                    st_n = ST_RUN;
            end
            default: begin
                vy_n = vy_upd;
                if ((state == ST_RISE) && (vy_upd >= 0))
                    st_n = ST_FALL;
                if ((y_step + $signed(12'(SPR_H))) >= $signed({2'b00, GroundY})) begin
                    y_n  = GroundY - 10'(SPR_H);
                    vy_n = '0;
                    st_n = ST_RUN;
                end else if (y_step < $signed(12'(Y_MIN))) begin
                    y_n  = 10'(Y_MIN);
                    vy_n = '0;
                    st_n = ST_FALL;
                end else begin
                    y_n = y_step[9:0];
                end
            end
        endcase
    end

    // Player registers: restart wins over a coincident frame tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_RUN;
            y     <= 10'(Y_START);
            vy    <= '0;
            page  <= '0;
            fcnt  <= '0;
        end else if (restart) begin
            state <= ST_RUN;
            y     <= 10'(Y_START);
            vy    <= '0;
            page  <= '0;
            fcnt  <= '0;
        end else if (tick) begin
            state <= st_n;
            y     <= y_n;
            vy    <= vy_n;
            page  <= page_n;
            fcnt  <= fcnt_n;
        end
    end

    // Displayed page: run cycle, shared airborne page, or the duck page.
    always_comb begin
        unique case (state)
            ST_RUN:  disp_page = page;
            ST_DUCK: disp_page = PAGE_W'(N_RUN + 1);
            default: disp_page = PAGE_W'(N_RUN);
        endcase
    end

    assign dx        = $signed({1'b0, DrawX}) - $signed(11'(X_POS));
    assign dy        = $signed({1'b0, DrawY}) - $signed({1'b0, y});
    assign in_box    = (dx >= 0) && (dx < $signed(11'(SPR_W))) &&
                       (dy >= 0) && (dy < $signed(11'(SPR_H)));
    assign duck_hide = (state == ST_DUCK) && (dy < $signed(11'(SPR_H - DUCK_H)));
    assign col_idx   = CW'(SPR_W - 1) - CW'(dx);

    assign rom_addr    = ADDR_W'(disp_page) * ADDR_W'(SPR_H) + ADDR_W'(dy);
    assign is_stickman = in_box && rom_data[col_idx] && !duck_hide;
    assign StickmanTop = (state == ST_DUCK) ? y + 10'(SPR_H - DUCK_H) : y;
    assign state_o     = state;

endmodule

// File: tb/tb_stickman_ctrl.sv
// Bench for stickman_ctrl: two instances (default ceiling and a low ceiling)
// driven in lockstep and compared against a frame-level behavioural model.
module tb_stickman_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_clk;
    logic        restart;
    logic [7:0]  keycode;
    logic [9:0]  DrawX, DrawY, GroundY;
    logic [9:0]  rom_addr0, rom_addr1;
    logic [55:0] rom_data0, rom_data1;
    logic [9:0]  top0, top1;
    logic [1:0]  st0, st1;
    logic        pix0, pix1;

    int checks = 0;
    int errors = 0;

    // Model state per instance: Y, vy, mode (0 run,1 rise,2 fall,3 duck), ticks spent running.
    int m_y[2], m_vy[2], m_st[2], m_rt[2];
    int ymin[2] = '{10, 200};
    int jl[6]   = '{238, 234, 231, 229, 228, 228};

    always #5 Clk = ~Clk;

    // Synthetic ROM contents, a different pattern per row.
    function automatic logic [55:0] rom_row(input logic [9:0] a);
        logic [13:0] t;
        t = {a, a[3:0] ^ 4'h9};
        return {t, ~t, t ^ 14'h1555, t[6:0], t[13:7]};
    endfunction

    assign rom_data0 = rom_row(rom_addr0);
    assign rom_data1 = rom_row(rom_addr1);

    stickman_ctrl u0 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .restart(restart),
        .keycode(keycode), .DrawX(DrawX), .DrawY(DrawY), .GroundY(GroundY),
        .rom_addr(rom_addr0), .rom_data(rom_data0), .StickmanTop(top0),
        .state_o(st0), .is_stickman(pix0)
    );

    stickman_ctrl #(.Y_MIN(200)) u1 (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .restart(restart),
        .keycode(keycode), .DrawX(DrawX), .DrawY(DrawY), .GroundY(GroundY),
        .rom_addr(rom_addr1), .rom_data(rom_data1), .StickmanTop(top1),
        .state_o(st1), .is_stickman(pix1)
    );

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_y[i] = 250; m_vy[i] = 0; m_st[i] = 0; m_rt[i] = 0;
        end
    endfunction

    // One frame of player physics straight from the game rules.
    function automatic void model_step(int i);
        int ny, nv, ns, g;
        g = int'(GroundY);
        case (m_st[i])
            0: begin
                m_rt[i]++;
                if (keycode == 8'h2C) begin m_st[i] = 1; m_vy[i] = -12; end
                else if (keycode == 8'h51) m_st[i] = 3;
                else if (m_y[i] + 80 < g) begin m_st[i] = 2; m_vy[i] = 0; end
            end
            3: if (keycode != 8'h51) m_st[i] = 0;
            default: begin
                ny = m_y[i] + m_vy[i];
                nv = (m_vy[i] + 1 > 10) ? 10 : m_vy[i] + 1;
                if (m_st[i] == 1 && keycode != 8'h2C && nv < -4) nv = -4;
                ns = m_st[i];
                if (m_st[i] == 1 && nv >= 0) ns = 2;
                if (ny + 80 >= g) begin m_y[i] = g - 80; nv = 0; ns = 0; end
                else if (ny < ymin[i]) begin m_y[i] = ymin[i]; nv = 0; ns = 2; end
                else m_y[i] = ny;
                m_vy[i] = nv;
                m_st[i] = ns;
            end
        endcase
    endfunction

    function automatic int exp_page(int i);
        if (m_st[i] == 0) return (m_rt[i] / 2) % 9;
        if (m_st[i] == 3) return 10;
        return 9;
    endfunction

    function automatic int exp_addr(int i, int y);
        return (exp_page(i) * 80 + (y - m_y[i])) & 1023;
    endfunction

    function automatic int exp_pix(int i, int x, int y);
        int dx, dy;
        logic [55:0] row;
        dx = x - 100;
        dy = y - m_y[i];
        if (dx < 0 || dx >= 56 || dy < 0 || dy >= 80) return 0;
        if (m_st[i] == 3 && dy < 32) return 0;
        row = rom_row(10'(exp_addr(i, y)));
        return int'(row[55 - dx]);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare one instance's outputs with the model, including a random pixel.
    task automatic check_dut(input int i, input string tag);
        int rx, ry;
        chk({tag, ".state"}, (i == 0) ? 32'(st0) : 32'(st1), m_st[i]);
        chk({tag, ".top"}, (i == 0) ? 32'(top0) : 32'(top1),
            (m_st[i] == 3) ? m_y[i] + 32 : m_y[i]);
        DrawX = 10'd100;
        DrawY = 10'(m_y[i]);
        #1;
        chk({tag, ".page_addr"}, (i == 0) ? 32'(rom_addr0) : 32'(rom_addr1), exp_page(i) * 80);
        rx = 90 + int'($urandom_range(0, 75));
        ry = m_y[i] - 10 + int'($urandom_range(0, 100));
        if (ry < 0) ry = 0;
        DrawX = 10'(rx);
        DrawY = 10'(ry);
        #1;
        chk({tag, ".addr"}, (i == 0) ? 32'(rom_addr0) : 32'(rom_addr1), exp_addr(i, ry));
        chk({tag, ".pix"}, (i == 0) ? 32'(pix0) : 32'(pix1), exp_pix(i, rx, ry));
    endtask

    // One frame strobe period; restart optionally held across it.
    task automatic do_tick(input bit rst_req);
        @(negedge Clk);
        restart   = rst_req;
        frame_clk = 1'b1;
        repeat (6) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (6) @(negedge Clk);
        restart = 1'b0;
        if (rst_req) model_reset();
        else begin model_step(0); model_step(1); end
    endtask

    initial begin
        int cnt;
        logic [7:0] keys[4];
        keys = '{8'h00, 8'h2C, 8'h51, 8'h11};
        Reset_n = 1'b0; frame_clk = 1'b0; restart = 1'b0; keycode = 8'h00;
        DrawX = '0; DrawY = '0; GroundY = 10'd330;
        model_reset();
        repeat (3) @(negedge Clk);
        check_dut(0, "reset0");
        check_dut(1, "reset1");
        Reset_n = 1'b1;

        // Run cycle paging.
        for (int k = 0; k < 18; k++) begin
            DrawX = 10'd100; DrawY = 10'd250; #1;
            chk("run_page", 32'(rom_addr0), (k / 2) * 80);
            do_tick(1'b0);
        end
        DrawX = 10'd100; DrawY = 10'd250; #1;
        chk("run_page_wrap", 32'(rom_addr0), 0);
        check_dut(0, "run0");

        // Short jump: one tick of jump key then release.
        keycode = 8'h2C;
        do_tick(1'b0);
        chk("short.top0", 32'(top0), 250);
        chk("short.st0", 32'(st0), 1);
        keycode = 8'h00;
        for (int k = 0; k < 6; k++) begin
            do_tick(1'b0);
            chk("short.seq", 32'(top0), jl[k]);
            check_dut(0, "short");
        end
        for (int k = 0; k < 40 && m_st[0] != 0; k++) begin
            do_tick(1'b0);
            check_dut(0, "short_fall");
        end
        chk("short.land_top", 32'(top0), 250);
        chk("short.land_st", 32'(st0), 0);
        check_dut(1, "short1");

        // Held jump: apex, ceiling clamp on the low-ceiling instance, landing.
        keycode = 8'h2C;
        for (int k = 1; k <= 13; k++) begin
            do_tick(1'b0);
            check_dut(0, "hold0");
            check_dut(1, "hold1");
            if (k == 7) begin
                chk("ceil.st1", 32'(st1), 2);
                chk("ceil.top1", 32'(top1), 200);
            end
        end
        chk("apex.st0", 32'(st0), 2);
        chk("apex.top0", 32'(top0), 172);
        DrawX = 10'd100; DrawY = 10'd172; #1;
        chk("apex.page", 32'(rom_addr0), 9 * 80);
        for (int k = 0; k < 40 && m_st[0] != 0; k++) begin
            do_tick(1'b0);
            chk("no_overshoot", 32'(top0 > 10'd250), 0);
            check_dut(0, "hfall0");
            check_dut(1, "hfall1");
        end
        chk("hold.land_top", 32'(top0), 250);

        // Asynchronous reset mid-jump.
        keycode = 8'h2C;
        repeat (3) do_tick(1'b0);
        keycode = 8'h00;
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        model_reset();
        chk("areset.st0", 32'(st0), 0);
        chk("areset.top0", 32'(top0), 250);
        check_dut(0, "areset0");
        check_dut(1, "areset1");
        @(negedge Clk);
        Reset_n = 1'b1;

        // Duck, and jump key while ducking.
        keycode = 8'h51;
        do_tick(1'b0);
        chk("duck.st", 32'(st0), 3);
        chk("duck.top", 32'(top0), 282);
        DrawX = 10'd100; DrawY = 10'd250; #1;
        chk("duck.page", 32'(rom_addr0), 800);
        cnt = 0;
        DrawY = 10'd260;
        for (int x = 100; x < 156; x++) begin
            DrawX = 10'(x); #1;
            if (pix0) cnt++;
        end
        chk("duck.hidden_row", 32'(cnt), 0);
        check_dut(0, "duck0");
        keycode = 8'h2C;
        do_tick(1'b0);
        chk("duck.no_jump", 32'(st0), 0);
        check_dut(0, "unduck0");
        keycode = 8'h00;
        do_tick(1'b0);

        // Restart held across a tick mid-jump.
        keycode = 8'h2C;
        repeat (3) do_tick(1'b0);
        keycode = 8'h00;
        do_tick(1'b1);
        chk("restart.top0", 32'(top0), 250);
        chk("restart.st0", 32'(st0), 0);
        check_dut(0, "restart0");
        check_dut(1, "restart1");

        // Random play: keys, floor height and occasional restarts.
        for (int k = 0; k < 250; k++) begin
            if ($urandom_range(0, 3) == 0) keycode = keys[$urandom_range(0, 3)];
            if ($urandom_range(0, 15) == 0) GroundY = ($urandom_range(0, 1) == 0) ? 10'd330 : 10'd360;
            do_tick($urandom_range(0, 39) == 0);
            check_dut(0, "rand0");
            check_dut(1, "rand1");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
